mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 115 +++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access pipeline stage (master) and
// the data memory or bus fabric (slave).
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time on the data
// bus, stalls upstream until ack or timeout, and registers the write-back.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_in,
    input  logic                      mem_data_rd_en_in,
    input  logic                      mem_data_wr_en_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    mem_access_stage_if.master        dmem,
    output logic                      stall_out,
    output logic                      reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic [DATA_WIDTH-1:0]     wb_data_out,
    output logic                      bus_error_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    state_t                    next_state;
    logic [7:0]                wait_cnt;
    logic                      cap_reg_wr_en;
    logic [REG_ADDR_WIDTH-1:0] cap_reg_wr_addr;
    logic                      access;
    logic                      timeout;

    assign access  = (mem_data_rd_en_in | mem_data_wr_en_in) & ~flush_in;
    assign timeout = (state == WAIT) & ~dmem.dmem_ack & (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (access) next_state = WAIT;
            WAIT:    if (dmem.dmem_ack || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall_out = 1'b0;
        case (state)
            IDLE:    stall_out = access;
            WAIT:    stall_out = ~dmem.dmem_ack;
            default: stall_out = 1'b0;
        endcase
    end

    // Bus hold registers and write-back registers; pipeline inputs are only
    // looked at in IDLE, so a flush can never abort an issued transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            wait_cnt        <= '0;
            cap_reg_wr_en   <= 1'b0;
            cap_reg_wr_addr <= '0;
            reg_wr_en_out   <= 1'b0;
            reg_wr_addr_out <= '0;
            wb_data_out     <= '0;
            bus_error_out   <= 1'b0;
        end else begin
            bus_error_out <= 1'b0;
            if (state == IDLE) begin
                if (access) begin
                    dmem.dmem_req   <= 1'b1;
                    dmem.dmem_we    <= mem_data_wr_en_in;
                    dmem.dmem_addr  <= alu_data_in[ADDR_WIDTH-1:0];
                    dmem.dmem_wdata <= mem_data_in;
                    wait_cnt        <= '0;
                    cap_reg_wr_en   <= reg_wr_en_in & ~mem_data_wr_en_in;
                    cap_reg_wr_addr <= reg_wr_addr_in;
                    reg_wr_en_out   <= 1'b0;
                end else begin
                    reg_wr_en_out   <= reg_wr_en_in & ~flush_in;
                    reg_wr_addr_out <= reg_wr_addr_in;
                    wb_data_out     <= alu_data_in;
                end
            end else if (dmem.dmem_ack) begin
                dmem.dmem_req   <= 1'b0;
                reg_wr_en_out   <= cap_reg_wr_en & ~dmem.dmem_we;
                reg_wr_addr_out <= cap_reg_wr_addr;
                wb_data_out     <= dmem.dmem_we ? '0 : dmem.dmem_rdata;
            end else if (timeout) begin
                dmem.dmem_req <= 1'b0;
                reg_wr_en_out <= 1'b0;
                bus_error_out <= 1'b1;
            end else begin
                wait_cnt      <= wait_cnt + 8'd1;
                reg_wr_en_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with an in-bench bus responder whose
// ack delay is chosen per transaction.
module tb_mem_access_stage;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int AW  = 20;
    localparam int TO  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush_in;
    logic           mem_data_rd_en_in;
    logic           mem_data_wr_en_in;
    logic [DW-1:0]  mem_data_in;
    logic [DW-1:0]  alu_data_in;
    logic           reg_wr_en_in;
    logic [RAW-1:0] reg_wr_addr_in;
    logic           stall_out;
    logic           reg_wr_en_out;
    logic [RAW-1:0] reg_wr_addr_out;
    logic [DW-1:0]  wb_data_out;
    logic           bus_error_out;

    mem_access_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_access_stage #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_in          (flush_in),
        .mem_data_rd_en_in (mem_data_rd_en_in),
        .mem_data_wr_en_in (mem_data_wr_en_in),
        .mem_data_in       (mem_data_in),
        .alu_data_in       (alu_data_in),
        .reg_wr_en_in      (reg_wr_en_in),
        .reg_wr_addr_in    (reg_wr_addr_in),
        .dmem              (bus),
        .stall_out         (stall_out),
        .reg_wr_en_out     (reg_wr_en_out),
        .reg_wr_addr_out   (reg_wr_addr_out),
        .wb_data_out       (wb_data_out),
        .bus_error_out     (bus_error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           en;
        logic [RAW-1:0] waddr;
        logic [DW-1:0]  wb;
        logic           err;
        logic           chk_data;
        int             stalls;
        int             reqs;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mk(logic en, logic [RAW-1:0] a, logic [DW-1:0] wb, logic err,
                                logic chk, int st, int rq);
        exp_t e;
        e.en = en; e.waddr = a; e.wb = wb; e.err = err;
        e.chk_data = chk; e.stalls = st; e.reqs = rq;
        return e;
    endfunction

    task automatic driveInputs(input logic rd, input logic wr, input logic fl, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] alu, input logic rwe, input logic [RAW-1:0] rwa);
        mem_data_rd_en_in = rd;
        mem_data_wr_en_in = wr;
        flush_in          = fl;
        mem_data_in       = wdata;
        alu_data_in       = alu;
        reg_wr_en_in      = rwe;
        reg_wr_addr_in    = rwa;
    endtask

    // Presents one instruction, holding it while stalled; ack_delay counts
    // request cycles before ack (negative = never ack).
    task automatic applyStimulus(input logic rd, input logic wr, input logic fl, input logic fl_late,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] alu,
                                 input logic rwe, input logic [RAW-1:0] rwa,
                                 input int ack_delay, input logic [DW-1:0] rdata, input exp_t e);
        exp_t got;
        int   stalls = 0;
        int   reqs   = 0;
        int   wcnt   = 0;
        bit   done   = 0;
        logic s;
        logic [AW-1:0] exp_addr;
        exp_addr = alu[AW-1:0];
        sb.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            driveInputs(rd, wr, (cyc == 0) ? fl : fl_late, wdata, alu, rwe, rwa);
            bus.dmem_ack   = bus.dmem_req && (ack_delay >= 0) && (wcnt == ack_delay);
            bus.dmem_rdata = bus.dmem_ack ? rdata : 32'hBAD0_BAD0;
            if (bus.dmem_req) begin
                reqs++;
                wcnt++;
                checkOutput("bus_addr", bus.dmem_addr, exp_addr);
                checkOutput("bus_we", bus.dmem_we, wr);
                checkOutput("bus_wdata", bus.dmem_wdata, wdata);
            end
            #2;
            s = stall_out;
            if (s) stalls++;
            @(posedge clk);
            #1;
            if (!s || bus_error_out) begin
                done = 1;
                got  = sb.pop_front();
                checkOutput("wb_en", reg_wr_en_out, got.en);
                checkOutput("bus_error", bus_error_out, got.err);
                if (got.chk_data) begin
                    checkOutput("wb_addr", reg_wr_addr_out, got.waddr);
                    checkOutput("wb_data", wb_data_out, got.wb);
                end
                checkOutput("stall_cycles", stalls, got.stalls);
                checkOutput("req_cycles", reqs, got.reqs);
            end else begin
                checkOutput("bubble_en", reg_wr_en_out, 1'b0);
            end
        end
        if (!done) begin
            checkOutput("completion_bound", 1'b0, 1'b1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        @(posedge clk);
        #1;
        checkOutput("err_one_cycle", bus_error_out, 1'b0);
        checkOutput("req_idle", bus.dmem_req, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        driveInputs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        #12;
        checkOutput("rst_req", bus.dmem_req, 1'b0);
        checkOutput("rst_wb_en", reg_wr_en_out, 1'b0);
        checkOutput("rst_wb_data", wb_data_out, '0);
        checkOutput("rst_err", bus_error_out, 1'b0);
        checkOutput("rst_stall", stall_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0000_1234, 1, 5'd7, -1, 32'h0,
                      mk(1, 5'd7, 32'h0000_1234, 0, 1, 0, 0));
        idleCycle();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0000_00A5, 1, 5'd3, 3, 32'hDEAD_BEEF,
                      mk(1, 5'd3, 32'hDEAD_BEEF, 0, 1, 4, 4));
        idleCycle();
        applyStimulus(0, 1, 0, 0, 32'h55AA_55AA, 32'h0000_0100, 1, 5'd5, 0, 32'h1357_9BDF,
                      mk(0, 5'd5, 32'h0, 0, 1, 1, 1));
        idleCycle();
        applyStimulus(1, 1, 0, 0, 32'h0F0F_0F0F, 32'h0000_0200, 1, 5'd8, 1, 32'h1234_5678,
                      mk(0, 5'd8, 32'h0, 0, 1, 2, 2));
        idleCycle();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0000_0ABC, 1, 5'd10, -1, 32'h0,
                      mk(0, 5'd10, 32'h0, 1, 0, 5, 4));
        idleCycle();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0000_0ABC, 1, 5'd10, 3, 32'h600D_F00D,
                      mk(1, 5'd10, 32'h600D_F00D, 0, 1, 4, 4));
        idleCycle();
        applyStimulus(1, 0, 1, 1, 32'h0, 32'h0000_0077, 1, 5'd3, 0, 32'h0,
                      mk(0, 5'd3, 32'h0000_0077, 0, 1, 0, 0));
        idleCycle();
        applyStimulus(1, 0, 0, 1, 32'h0, 32'hABC1_2345, 1, 5'd9, 1, 32'hCAFE_F00D,
                      mk(1, 5'd9, 32'hCAFE_F00D, 0, 1, 2, 2));
        idleCycle();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, 5'd31, -1, 32'h0,
                      mk(0, 5'd31, 32'hFFFF_FFFF, 0, 1, 0, 0));
        idleCycle();

        // Reset in the middle of a WAIT, followed by a stale ack
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 1'b0, '0, 32'h0000_5A5A, 1'b1, 5'd6);
        @(negedge clk);
        driveInputs(1'b1, 1'b0, 1'b0, 32'h0000_1111, 32'h0000_0321, 1'b1, 5'd4);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checkOutput("pre_rst_req", bus.dmem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req", bus.dmem_req, 1'b0);
        checkOutput("async_rst_addr", bus.dmem_addr, '0);
        checkOutput("async_rst_wdata", bus.dmem_wdata, '0);
        checkOutput("async_rst_we", bus.dmem_we, 1'b0);
        checkOutput("async_rst_wb_addr", reg_wr_addr_out, '0);
        checkOutput("async_rst_wb_data", wb_data_out, '0);
        checkOutput("async_rst_wb_en", reg_wr_en_out, 1'b0);
        checkOutput("async_rst_stall", stall_out, 1'b0);
        @(negedge clk);
        rst            = 1'b0;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        #2;
        checkOutput("late_ack_stall", stall_out, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("late_ack_req", bus.dmem_req, 1'b0);
        checkOutput("late_ack_wb_en", reg_wr_en_out, 1'b0);
        checkOutput("late_ack_wb_data", wb_data_out, '0);
        checkOutput("late_ack_err", bus_error_out, 1'b0);
        idleCycle();

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
